// File: rtl/tt_um_kalman.sv
// tt_um_kalman -- scalar fixed-point Kalman filter, Tiny Tapeout user tile.
//
// Each accepted 8-bit measurement z updates the Q8.8 estimate x. The gain
// K = P/(P+R) is found by a sequential restoring divide, so one update takes
// 10 cycles after the accept edge (PRED, 8 x DIV, UPD).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      tile select (ignored)
//   ui_in    measurement z, or configuration data
//   uio_in   [0] meas_valid, [1] cfg_we, [3:2] sel, [7:4] unused
//   uo_out   estimate x[15:8] (debug readout mux when KALMAN_DEBUG_EN)
//   uio_out  [7] busy, [6] out_valid, [5:0] zero
//   uio_oe   constant 8'hF0
//
// Optional build macro: KALMAN_DEBUG_EN -- with cfg_we low, sel picks the
// readout on uo_out: 00 x[15:8], 01 x[7:0], 10 P[15:8], 11 K.
module tt_um_kalman #(
  parameter logic [15:0] P_INIT = 16'h1000,
  parameter logic [7:0]  Q_INIT = 8'd1,
  parameter logic [7:0]  R_INIT = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, PRED, DIV, UPD} state_t;

  state_t state, state_nxt;

  logic        meas_valid, cfg_we;
  logic [1:0]  sel;
  logic [15:0] x, p;
  logic [7:0]  q_reg, r_reg, k, z;
  logic [16:0] s, rem;
  logic [7:0]  quo;
  logic        q8, s_zero, out_valid;
  logic [2:0]  cnt;
  logic        unused;

  assign meas_valid = uio_in[0];
  assign cfg_we     = uio_in[1];
  assign sel        = uio_in[3:2];
  assign unused     = &{1'b0, ena, uio_in[7:4]};

  // Prediction and innovation covariance S = P_pred + R
  logic [16:0] p_sum, s_pred;
  logic [15:0] p_pred;
  logic        pred_ge;
  assign p_sum   = {1'b0, p} + {5'b0, q_reg, 4'b0};
  assign p_pred  = p_sum[16] ? 16'hFFFF : p_sum[15:0];
  assign s_pred  = {1'b0, p_pred} + {5'b0, r_reg, 4'b0};
  // Quotient bit 8 of P*256/S is resolved in PRED (it is set only when R=0),
  // leaving the eight fractional bits for the DIV cycles.
  assign pred_ge = {1'b0, p_pred} >= s_pred;

  // One restoring-divide step
  logic [17:0] rem_sh, rem_diff;
  logic        ge;
  assign rem_sh   = {rem, 1'b0};
  assign ge       = rem_sh >= {1'b0, s};
  assign rem_diff = rem_sh - {1'b0, s};

  // Update arithmetic
  logic signed [16:0] e;
  logic signed [25:0] prod;
  logic signed [18:0] x_sum;
  logic        [23:0] kp;
  assign e     = $signed({1'b0, z, 8'h00}) - $signed({1'b0, x});
  // Low 26 bits of the product are sign-correct; |e*K| < 2^25.
  assign prod  = $signed({{9{e[16]}}, e}) * $signed({18'b0, k});
  assign x_sum = $signed({3'b000, x}) + $signed({prod[25], prod[25:8]});
  assign kp    = {16'b0, k} * {8'b0, p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (meas_valid && !cfg_we) state_nxt = PRED;
      PRED:    state_nxt = DIV;
      DIV:     if (cnt == 3'd7) state_nxt = UPD;
      UPD:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      p         <= P_INIT;
      q_reg     <= Q_INIT;
      r_reg     <= R_INIT;
      k         <= '0;
      z         <= '0;
      s         <= '0;
      rem       <= '0;
      quo       <= '0;
      q8        <= 1'b0;
      s_zero    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            case (sel)
              2'b00: q_reg <= ui_in;
              2'b01: r_reg <= ui_in;
              2'b10: begin
                x <= {ui_in, 8'h00};
                p <= P_INIT;
              end
              default: ;
            endcase
          end else if (meas_valid) begin
            z <= ui_in;
          end
        end
        PRED: begin
          p      <= p_pred;
          s      <= s_pred;
          q8     <= pred_ge;
          s_zero <= (s_pred == '0);
          rem    <= pred_ge ? ({1'b0, p_pred} - s_pred) : {1'b0, p_pred};
          cnt    <= '0;
        end
        DIV: begin
          rem <= ge ? rem_diff[16:0] : rem_sh[16:0];
          quo <= {quo[6:0], ge};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (s_zero)  k <= '0;
            else if (q8) k <= '1;
            else         k <= {quo[6:0], ge};
          end
        end
        UPD: begin
          x         <= x_sum[15:0];
          p         <= p - kp[23:8];
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef KALMAN_DEBUG_EN
  always_comb begin
    uo_out = x[15:8];
    if (!cfg_we) begin
      case (sel)
        2'b00: uo_out = x[15:8];
        2'b01: uo_out = x[7:0];
        2'b10: uo_out = p[15:8];
        2'b11: uo_out = k;
        default: uo_out = x[15:8];
      endcase
    end
  end
`else
  assign uo_out = x[15:8];
`endif

  assign uio_out = {(state != IDLE), out_valid, 6'b0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_kalman.sv
module tb_tt_um_kalman;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_kalman dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state (plain integers)
  int m_x, m_p, m_q, m_r, m_k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_p = 4096; m_q = 1; m_r = 16; m_k = 0;
  endtask

  task automatic model_cfg(input int sel, input int d);
    if (sel == 0) m_q = d;
    else if (sel == 1) m_r = d;
    else if (sel == 2) begin m_x = d * 256; m_p = 4096; end
  endtask

  // K = P_pred/(P_pred+R) in 1/256ths, clamped; x moves toward z by K*e (floor)
  task automatic model_meas(input int z);
    int pp, s, kk, e;
    pp = m_p + m_q * 16;
    if (pp > 65535) pp = 65535;
    s = pp + m_r * 16;
    if (s == 0) kk = 0;
    else begin
      kk = (pp * 256) / s;
      if (kk > 255) kk = 255;
    end
    e = z * 256 - m_x;
    m_x = m_x + ((e * kk) >>> 8);
    m_p = pp - (kk * pp) / 256;
    m_k = kk;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    ui_in = d;
    uio_in = {4'b0, sel, 2'b10};
    @(negedge clk);
    uio_in = '0;
    model_cfg(int'(sel), int'(d));
  endtask

  // One measurement; with poke set, cfg writes are attempted while busy.
  task automatic measure(input logic [7:0] zv, input bit poke, input string tag);
    int c;
    @(negedge clk);
    ui_in = zv;
    uio_in = 8'h01;
    @(posedge clk);
    model_meas(int'(zv));
    @(negedge clk);
    uio_in = '0;
    c = 1;
    check({tag, "_busy"}, {31'b0, uio_out[7]}, 32'd1);
    while (!uio_out[6] && c < 40) begin
      @(negedge clk);
      c++;
      if (poke && c == 3) begin ui_in = 8'd0; uio_in = 8'b0000_0110; end
      if (poke && c == 4) begin ui_in = 8'd0; uio_in = 8'b0000_1010; end
      if (poke && c == 5) uio_in = '0;
    end
    check({tag, "_latency"}, c, 32'd11);
    check({tag, "_busy_done"}, {31'b0, uio_out[7]}, 32'd0);
    check({tag, "_uo"}, {24'b0, uo_out}, m_x >> 8);
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, uio_out[6]}, 32'd0);
  endtask

  initial begin
    int idx[$];
    int cyc;
    model_reset();

    // Reset state
    #12;
    check("rst_uo", {24'b0, uo_out}, 32'd0);
    check("rst_uio", {24'b0, uio_out}, 32'd0);
    check("rst_oe", {24'b0, uio_oe}, 32'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'b0, uio_out[7]}, 32'd0);

    // Defaults, z=100
    measure(8'd100, 1'b0, "z100");
    check("z100_const", {24'b0, uo_out}, 32'd93);
    check("z100_model_x", m_x, 32'd24000);
`ifdef KALMAN_DEBUG_EN
    uio_in = 8'b0000_1100; #1;
    check("dbg_k", {24'b0, uo_out}, 32'd240);
    uio_in = 8'b0000_1000; #1;
    check("dbg_p", {24'b0, uo_out}, 32'd1);
    uio_in = 8'b0000_0100; #1;
    check("dbg_xlo", {24'b0, uo_out}, 32'hC0);
    uio_in = '0; #1;
`endif

    // Negative innovation
    measure(8'd50, 1'b0, "z50");
    check("z50_const", {24'b0, uo_out}, 32'd71);

    // R=0 clamps K to 255
    cfg(2'b01, 8'd0);
    cfg(2'b10, 8'd0);
    check("xinit_uo", {24'b0, uo_out}, 32'd0);
    measure(8'd200, 1'b0, "z200");
    check("z200_const", {24'b0, uo_out}, 32'd199);
`ifdef KALMAN_DEBUG_EN
    uio_in = 8'b0000_1100; #1;
    check("dbg_kclamp", {24'b0, uo_out}, 32'd255);
    uio_in = '0; #1;
`endif

    // Config writes during busy must be ignored
    cfg(2'b01, 8'd16);
    measure(8'd10, 1'b1, "poke");
    measure(8'd120, 1'b0, "after_poke");

    // cfg_we has priority over meas_valid
    @(negedge clk);
    ui_in = 8'h30;
    uio_in = 8'b0000_1011;
    @(negedge clk);
    uio_in = '0;
    model_cfg(2, 8'h30);
    check("prio_busy", {31'b0, uio_out[7]}, 32'd0);
    check("prio_uo", {24'b0, uo_out}, 32'h30);

    // Reserved sel has no effect
    cfg(2'b11, 8'd99);
    measure(8'd77, 1'b0, "sel11");

    // Back-to-back with meas_valid held high
    @(negedge clk);
    ui_in = 8'd180;
    uio_in = 8'h01;
    cyc = 0;
    while (idx.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (uio_out[6]) begin
        idx.push_back(cyc);
        model_meas(180);
        check("b2b_uo", {24'b0, uo_out}, m_x >> 8);
        if (idx.size() == 3) uio_in = '0;
      end
    end
    check("b2b_count", idx.size(), 32'd3);
    for (int i = 0; i < idx.size(); i++) check("b2b_spacing", idx[i], 11 * (i + 1));
    @(negedge clk);
    check("b2b_stop", {24'b0, uio_out}, 32'd0);

    // Randomized measurements and configuration
    for (int n = 0; n < 16; n++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) cfg(2'b00, 8'($urandom_range(0, 255)));
      else if (r == 1) cfg(2'b01, 8'($urandom_range(0, 255)));
      else if (r == 2) cfg(2'b01, 8'd0);
      else if (r == 3) cfg(2'b10, 8'($urandom_range(0, 255)));
      measure(8'($urandom_range(0, 255)), 1'b0, "rand");
    end

    // Reset mid-update aborts it
    @(negedge clk);
    ui_in = 8'd250;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_uo", {24'b0, uo_out}, 32'd0);
    check("midrst_uio", {24'b0, uio_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_busy", {31'b0, uio_out[7]}, 32'd0);
    measure(8'd100, 1'b0, "post_rst");
    check("post_rst_const", {24'b0, uo_out}, 32'd93);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
